video_pixel_shifter: RTL
========================

// Module: video_pixel_shifter
// PURPOSE
//  Downstream stage of the CRTC timing generator. Per character time: captures ma/ra/de/syncs,
//  fetches the screen code from VRAM, fetches the glyph row from char ROM, then serialises
//  8 pixels MSB-first. Syncs are delayed one character so they stay aligned with pixels.
//  Sits between the CRTC outputs and the board video/sync pins; a memory arbiter serves its reads.
// PARAMETERS
//  VRAM_BASE      7'h20   addr[16:10] of VRAM window; VRAM addr = {VRAM_BASE, ma[9:0]}
//  CHARROM_BASE   6'h3C   addr[16:11] of char ROM; ROM addr = {CHARROM_BASE, graphic_i, code[6:0], ra[2:0]}
//  PIXELS         8       pixels per character (shift register width)
// PORTS
//  setup_clk_i    in   1   system clock; all state on rising edge
//  reset_i        in   1   asynchronous, active-high reset
//  cclk_en_i      in   1   character-clock enable, 1 setup_clk cycle wide
//  pix_en_i       in   1   pixel-clock enable, PIXELS strobes per character period
//  de_i           in   1   CRTC display enable
//  ma_i           in   14  CRTC memory address
//  ra_i           in   5   CRTC raster (row) address
//  h_sync_i       in   1   CRTC horizontal sync
//  v_sync_i       in   1   CRTC vertical sync
//  graphic_i      in   1   char set select (0 = upper/graphics, 1 = lower/upper)
//  rd_req_o       out  1   memory read request
//  rd_addr_o      out  17  memory read address
//  rd_ack_i       in   1   1-cycle ack; rd_data_i valid same cycle
//  rd_data_i      in   8   memory read data
//  video_o        out  1   pixel out
//  h_sync_o       out  1   h_sync delayed one character
//  v_sync_o       out  1   v_sync delayed one character
//  underrun_o     out  1   1-cycle pulse: fetch not complete at character boundary
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; shift reg 0; stale/pending flags 0.
//  Capture: on cclk_en_i, latch ma, ra, de, h_sync, v_sync into stage-0 regs; set pending.
//  FSM (advances every setup_clk, not gated by cclk_en):
//   IDLE  : pending -> clear pending; rd_addr_o={VRAM_BASE,ma[9:0]}; rd_req_o=1; -> VRAM.
//   VRAM  : hold req/addr until rd_ack_i; on ack latch code=rd_data_i; rd_addr_o=ROM addr; -> ROM.
//   ROM   : hold req/addr until rd_ack_i; on ack latch pattern; rd_req_o=0; -> DONE.
//   DONE  : wait; result held until next cclk_en_i, then -> IDLE (pending already set).
//  rd_req_o/rd_addr_o never change while req high and unacked; ack while IDLE/DONE ignored.
//  Load (on cclk_en_i, same edge as capture): stage-1 <= stage-0 syncs; shift reg <= pixels:
//   base = (de && ra[4:3]==0) ? pattern : 8'h00; out = de ? base ^ {8{code[7]}} : 8'h00.
//   h_sync_o/v_sync_o update on this edge -> latency exactly one character period from input.
//  Underrun: cclk_en_i while FSM in VRAM/ROM -> load 8'h00, underrun_o=1 one cycle, mark
//   in-flight fetch stale; it completes normally (req held to ack), result discarded, FSM -> IDLE
//   and immediately starts the newly pending character. Stale cleared on entry to IDLE.
//  Shift: on pix_en_i (and not load cycle) video_o<=sr[PIXELS-1]; sr<=sr<<1, fill 0.
//   Load and pix_en_i same cycle: load wins; video_o takes new sr MSB.
//  ma[13:10] ignored; widths fixed: code 8b, pattern 8b, ROM row index ra[2:0].
//  Reset mid-fetch: rd_req_o drops asynchronously; arbiter must tolerate abandoned request.
// STRUCTURE
//  video_pkg: fetch_state_t enum {IDLE,VRAM,ROM,DONE}; VRAM_BASE/CHARROM_BASE defaults.
//  Sub-module video_shift_reg (load/shift/fill, PIXELS param); FSM+capture in top.
//  Target ~200 lines total.
// TESTING
//  Reset: assert reset_i mid-ROM fetch -> all outputs 0 same cycle, FSM IDLE after release.
//  Normal char: ma=0x005, ra=2, de=1, code=0x01, ROM[{3C,0,01,2}]=0x3C -> rd_addr 0x08005 then
//   0x1E00A, video_o = 0,0,1,1,1,1,0,0 next char period.
//  Reverse/blank rows: code=0x81, pattern 0x3C -> 1,1,0,0,0,0,1,1; ra=8 -> 1x8; de=0 -> 0x8.
//  Sync delay: h_sync_i rises at cclk N -> h_sync_o rises at cclk N+1 edge, not before.
//  Underrun: withhold rd_ack_i past next cclk_en -> underrun_o pulse, 8 zero pixels, stale data
//   not displayed, following char fetched and displayed correctly.
//  Back-to-back: ack on 1st cycle each -> 80 consecutive chars, no underrun, pixel stream matches model.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and defaults for the character-mode pixel shifter.
package video_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StVram,
    StRom,
    StDone
  } fetch_state_t;

  localparam logic [6:0] VramBaseDefault    = 7'h20;
  localparam logic [5:0] CharRomBaseDefault = 6'h3C;

  // Pixels for one character: raster rows 8..31 are blank, code[7] reverses the cell.
  function automatic logic [7:0] char_pixels(input logic       de,
                                             input logic [4:0] ra,
                                             input logic [7:0] code,
                                             input logic [7:0] pattern);
    logic [7:0] base;
    base = (de && (ra[4:3] == 2'b00)) ? pattern : 8'h00;
    return de ? (base ^ {8{code[7]}}) : 8'h00;
  endfunction

endpackage

// File: rtl/video_shift_reg.sv
// Parallel-load, MSB-first pixel serialiser with zero fill.
module video_shift_reg #(
  parameter int unsigned PIXELS = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [PIXELS-1:0] load_data_i,
  input  logic              shift_i,
  output logic              pixel_o
);

  logic [PIXELS-1:0] sr_q;
  logic              pixel_q;

  // Load has priority; a coincident shift strobe emits the new MSB straight away so the
  // character still produces exactly PIXELS pixels.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q    <= '0;
      pixel_q <= 1'b0;
    end else if (load_i) begin
      if (shift_i) begin
        pixel_q <= load_data_i[PIXELS-1];
        sr_q    <= {load_data_i[PIXELS-2:0], 1'b0};
      end else begin
        sr_q    <= load_data_i;
      end
    end else if (shift_i) begin
      pixel_q <= sr_q[PIXELS-1];
      sr_q    <= {sr_q[PIXELS-2:0], 1'b0};
    end
  end

  assign pixel_o = pixel_q;

endmodule

// File: rtl/video_pixel_shifter.sv
// Character fetch (VRAM code, then char ROM row) and pixel serialisation behind the CRTC.
module video_pixel_shifter
  import video_pkg::*;
#(
  parameter logic [6:0]  VRAM_BASE    = VramBaseDefault,
  parameter logic [5:0]  CHARROM_BASE = CharRomBaseDefault,
  parameter int unsigned PIXELS       = 8
) (
  input  logic        setup_clk_i,
  input  logic        reset_i,
  input  logic        cclk_en_i,
  input  logic        pix_en_i,
  input  logic        de_i,
  input  logic [13:0] ma_i,
  input  logic [4:0]  ra_i,
  input  logic        h_sync_i,
  input  logic        v_sync_i,
  input  logic        graphic_i,
  output logic        rd_req_o,
  output logic [16:0] rd_addr_o,
  input  logic        rd_ack_i,
  input  logic [7:0]  rd_data_i,
  output logic        video_o,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        underrun_o
);

  fetch_state_t state_q, state_d;

  // Stage 0: the character currently being fetched.
  logic [9:0]  ma_q;
  logic [4:0]  ra_q;
  logic        de_q;
  logic        hs0_q, vs0_q;
  // Stage 1: syncs aligned with the pixels being shifted out.
  logic        h_sync_q, v_sync_q;

  logic        pending_q, pending_d;
  logic        stale_q, stale_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  pattern_q, pattern_d;
  logic        req_q, req_d;
  logic [16:0] addr_q, addr_d;
  logic        underrun_q, underrun_d;

  logic        fetch_busy;
  logic [7:0]  load_byte;
  logic [PIXELS-1:0] load_pixels;

  // Only the low 10 bits of ma address the VRAM window.
  logic unused_ma;
  assign unused_ma = ^ma_i[13:10];

  // Capture the CRTC outputs and advance the sync pipeline once per character.
  always_ff @(posedge setup_clk_i or posedge reset_i) begin
    if (reset_i) begin
      ma_q     <= '0;
      ra_q     <= '0;
      de_q     <= 1'b0;
      hs0_q    <= 1'b0;
      vs0_q    <= 1'b0;
      h_sync_q <= 1'b0;
      v_sync_q <= 1'b0;
    end else if (cclk_en_i) begin
      ma_q     <= ma_i[9:0];
      ra_q     <= ra_i;
      de_q     <= de_i;
      hs0_q    <= h_sync_i;
      vs0_q    <= v_sync_i;
      h_sync_q <= hs0_q;
      v_sync_q <= vs0_q;
    end
  end

  assign fetch_busy = (state_q == StVram) || (state_q == StRom);

  // Fetch FSM next state; request/address only move on entry to a state or on ack.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    stale_d    = stale_q;
    code_d     = code_q;
    pattern_d  = pattern_q;
    req_d      = req_q;
    addr_d     = addr_q;
    underrun_d = 1'b0;

    // Character boundary arrived before the fetch finished: its result must not be shown.
    if (cclk_en_i && fetch_busy) begin
      underrun_d = 1'b1;
      stale_d    = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          pending_d = 1'b0;
          req_d     = 1'b1;
          addr_d    = {VRAM_BASE, ma_q};
          state_d   = StVram;
        end
      end
      StVram: begin
        if (rd_ack_i) begin
          code_d  = rd_data_i;
          addr_d  = {CHARROM_BASE, graphic_i, rd_data_i[6:0], ra_q[2:0]};
          state_d = StRom;
        end
      end
      StRom: begin
        if (rd_ack_i) begin
          req_d = 1'b0;
          if (stale_q || cclk_en_i) begin
            state_d = StIdle;
            stale_d = 1'b0;
          end else begin
            pattern_d = rd_data_i;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        if (cclk_en_i) begin
          state_d = StIdle;
        end
      end
    endcase

    if (cclk_en_i) begin
      pending_d = 1'b1;
    end
  end

  // Fetch FSM and memory-interface registers.
  always_ff @(posedge setup_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      stale_q    <= 1'b0;
      code_q     <= '0;
      pattern_q  <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      stale_q    <= stale_d;
      code_q     <= code_d;
      pattern_q  <= pattern_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      underrun_q <= underrun_d;
    end
  end

  // Only a completed fetch is displayed; anything else blanks the character.
  always_comb begin
    load_byte = 8'h00;
    if (state_q == StDone) begin
      load_byte = char_pixels(de_q, ra_q, code_q, pattern_q);
    end
  end

  assign load_pixels = PIXELS'(load_byte);

  video_shift_reg #(
    .PIXELS (PIXELS)
  ) u_shift_reg (
    .clk_i       (setup_clk_i),
    .rst_i       (reset_i),
    .load_i      (cclk_en_i),
    .load_data_i (load_pixels),
    .shift_i     (pix_en_i),
    .pixel_o     (video_o)
  );

  assign rd_req_o   = req_q;
  assign rd_addr_o  = addr_q;
  assign h_sync_o   = h_sync_q;
  assign v_sync_o   = v_sync_q;
  assign underrun_o = underrun_q;

endmodule
